// File: rtl/fir_mac_scheduler_pkg.sv
// Shared globals for the FIR MAC scheduler: data format, FSM state type and
// the common fixed-point multiply used by the accumulate path.
package fir_mac_scheduler_pkg;

  localparam int DATA_SIZE = 32;
  // Fractional bits of the fixed-point format (Q15.16 for DATA_SIZE=32).
  localparam int BITS = 16;

  localparam logic signed [2*DATA_SIZE-1:0] ROUND_HALF = (2*DATA_SIZE)'(1) << (BITS-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } fsm_state_t;

  // Full-precision signed product, round half up, rescale back to DATA_SIZE.
  // Upper bits are dropped after the rescale, so out-of-range products wrap.
  function automatic logic signed [DATA_SIZE-1:0] MULTIPLY_ROUNDING(
    input logic signed [DATA_SIZE-1:0] a,
    input logic signed [DATA_SIZE-1:0] b
  );
    logic signed [2*DATA_SIZE-1:0] prod;
    prod = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
    prod = prod + ROUND_HALF;
    prod = prod >>> BITS;
    return prod[DATA_SIZE-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
// Round-robin arbiter: first active request at or after the pointer wins.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    pointer,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(pointer) + i) % N_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shares one MAC between N_REQ FIR requesters: one burst of NUM_TAPS
// multiply-accumulates per output sample, result pushed into the output FIFO.
//
// state | meaning
// IDLE  | no burst; arbitrate, clear accumulator and operands on a grant
// MAC   | register winner's tap/coef, accumulate previous product
// DRAIN | accumulate the last product, capture result and owner
// WRITE | wait for FIFO space, write result, pulse done, advance pointer
module fir_mac_scheduler
  import fir_mac_scheduler_pkg::*;
#(
  parameter int NUM_TAPS = 32,
  parameter int N_REQ    = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req,
  output logic [N_REQ-1:0]                   gnt,
  output logic [$clog2(NUM_TAPS)-1:0]        tap_idx,
  input  logic [N_REQ-1:0][DATA_SIZE-1:0]    tap_dout,
  input  logic [N_REQ-1:0][DATA_SIZE-1:0]    coef_dout,
  output logic [N_REQ-1:0]                   done,
  input  logic                               y_out_full,
  output logic                               y_out_wr_en,
  output logic [DATA_SIZE-1:0]               y_out_din,
  output logic [$clog2(N_REQ)-1:0]           y_out_id
);

  localparam int TW = $clog2(NUM_TAPS);
  localparam int IW = $clog2(N_REQ);

  fsm_state_t                  state;
  logic [IW-1:0]               pointer;
  logic [IW-1:0]               winner_idx;
  logic signed [DATA_SIZE-1:0] acc;
  logic signed [DATA_SIZE-1:0] op_tap;
  logic signed [DATA_SIZE-1:0] op_coef;
  logic signed [DATA_SIZE-1:0] acc_sum;
  logic [N_REQ-1:0]            arb_winner;
  logic                        arb_valid;
  logic [IW-1:0]               arb_idx;
  logic                        write_fire;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (IW)
  ) u_arb (
    .req     (req),
    .pointer (pointer),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  // One-hot winner to binary index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_winner[i]) arb_idx = IW'(i);
    end
  end

  // Accumulator wraps modulo 2^DATA_SIZE by construction.
  assign acc_sum = acc + MULTIPLY_ROUNDING(op_tap, op_coef);

  // The FIFO handshake has to react to full in the same cycle, so the write
  // strobe and done pulse are the WRITE state qualified by !full.
  assign write_fire  = (state == WRITE) && !y_out_full;
  assign y_out_wr_en = write_fire;
  assign done        = write_fire ? (N_REQ'(1) << winner_idx) : '0;

  // Burst sequencing, operand pipeline, accumulator and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      tap_idx    <= '0;
      acc        <= '0;
      op_tap     <= '0;
      op_coef    <= '0;
      pointer    <= '0;
      winner_idx <= '0;
      y_out_din  <= '0;
      y_out_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            winner_idx <= arb_idx;
            gnt        <= arb_winner;
            acc        <= '0;
            op_tap     <= '0;
            op_coef    <= '0;
            tap_idx    <= '0;
            state      <= MAC;
          end
        end
        MAC: begin
          op_tap  <= tap_dout[winner_idx];
          op_coef <= coef_dout[winner_idx];
          acc     <= acc_sum;
          if (tap_idx == TW'(NUM_TAPS-1)) begin
            state <= DRAIN;
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
        end
        DRAIN: begin
          acc       <= acc_sum;
          y_out_din <= acc_sum;
          y_out_id  <= winner_idx;
          state     <= WRITE;
        end
        WRITE: begin
          if (!y_out_full) begin
            gnt     <= '0;
            pointer <= (winner_idx == IW'(N_REQ-1)) ? '0 : winner_idx + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: table of single bursts with
// hand-computed results, then sequences for arbitration, FIFO back-pressure,
// mid-burst reset and requester drop.
module tb_fir_mac_scheduler;
  import fir_mac_scheduler_pkg::*;

  localparam int NUM_TAPS = 32;
  localparam int N_REQ    = 2;
  localparam int LAT      = NUM_TAPS + 2;

  localparam logic [31:0] ONE     = 32'h0001_0000;
  localparam logic [31:0] HALF    = 32'h0000_8000;
  localparam logic [31:0] NHALF   = 32'hFFFF_8000;
  localparam logic [31:0] R0_EXP  = 32'h0020_0000;  // 32 x (1.0 * 1.0)
  localparam logic [31:0] R1_EXP  = 32'h0000_0020;  // 32 x round(1 lsb * 0.5)

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       gnt;
  logic [4:0]       tap_idx;
  logic [1:0][31:0] tap_dout;
  logic [1:0][31:0] coef_dout;
  logic [1:0]       done;
  logic             y_out_full = 1'b0;
  logic             y_out_wr_en;
  logic [31:0]      y_out_din;
  logic [0:0]       y_out_id;

  logic [31:0] base [2];
  logic [31:0] step [2];
  logic [31:0] coef [2];

  int tests = 0;
  int failed = 0;
  int wr_count = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;

  typedef struct {
    string       name;
    int          rq;
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] coef;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  fir_mac_scheduler #(
    .NUM_TAPS (NUM_TAPS),
    .N_REQ    (N_REQ)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .gnt         (gnt),
    .tap_idx     (tap_idx),
    .tap_dout    (tap_dout),
    .coef_dout   (coef_dout),
    .done        (done),
    .y_out_full  (y_out_full),
    .y_out_wr_en (y_out_wr_en),
    .y_out_din   (y_out_din),
    .y_out_id    (y_out_id)
  );

  always #5 clock = ~clock;

  // Requester models: tap k = base + k*step, constant coefficient.
  always_comb begin
    tap_dout  = '0;
    coef_dout = '0;
    for (int r = 0; r < N_REQ; r++) begin
      tap_dout[r]  = base[r] + 32'(tap_idx) * step[r];
      coef_dout[r] = coef[r];
    end
  end

  // Count FIFO writes and done pulses over the whole run.
  always @(posedge clock) begin
    if (y_out_wr_en) wr_count <= wr_count + 1;
    if (done[0]) done0_cnt <= done0_cnt + 1;
    if (done[1]) done1_cnt <= done1_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req_cfg(input int r, input logic [31:0] b, input logic [31:0] s,
                             input logic [31:0] c);
    base[r] = b;
    step[r] = s;
    coef[r] = c;
  endtask

  // Tick until the FIFO write fires; n = cycles since the caller's cycle 0.
  task automatic wait_write(output int n, output int gcyc);
    n = 0;
    gcyc = 0;
    while (1) begin
      tick();
      n++;
      if (gnt != 2'b00) gcyc++;
      if (y_out_wr_en || n >= 200) break;
    end
    check("write_seen", 32'(y_out_wr_en), 32'd1);
  endtask

  task automatic wait_tap(input logic [4:0] idx, input logic [1:0] g);
    int n;
    n = 0;
    while (!(tap_idx == idx && gnt == g) && n < 100) begin
      tick();
      n++;
    end
    check("tap_reached", 32'(tap_idx), 32'(idx));
  endtask

  initial begin
    int n, g, k, wr0, d0, d1, exp_d0, exp_d1;
    int ids [4];
    int cyc [4];
    logic [31:0] dins [4];

    vecs[0] = '{"ones_x_ones",     0, ONE,          32'h0,       ONE,   R0_EXP};
    vecs[1] = '{"mixed_sign",      1, 32'hFFF0_0000, 32'h0001_0000, NHALF, 32'h0008_0000};
    vecs[2] = '{"overflow_wrap",   0, 32'h7FFF_0000, 32'h0,       ONE,   32'hFFE0_0000};
    vecs[3] = '{"round_pos_half",  1, 32'h1,        32'h0,       HALF,  32'h0000_0020};
    vecs[4] = '{"round_neg_half",  0, 32'h1,        32'h0,       NHALF, 32'h0000_0000};
    vecs[5] = '{"round_neg_3lsb",  1, 32'h3,        32'h0,       NHALF, 32'hFFFF_FFE0};
    vecs[6] = '{"ramp_taps",       0, 32'h0,        ONE,         ONE,   32'h01F0_0000};

    for (int r = 0; r < N_REQ; r++) set_req_cfg(r, 32'h0, 32'h0, 32'h0);

    // Reset state.
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(y_out_wr_en), 32'd0);
    check("rst_din", y_out_din, 32'd0);
    check("rst_id", 32'(y_out_id), 32'd0);
    check("rst_tap_idx", 32'(tap_idx), 32'd0);
    reset = 1'b0;

    // Table of single bursts.
    exp_d0 = 0;
    exp_d1 = 0;
    for (int i = 0; i < 7; i++) begin
      set_req_cfg(vecs[i].rq, vecs[i].base, vecs[i].step, vecs[i].coef);
      if (vecs[i].rq == 0) exp_d0++; else exp_d1++;
      req = 2'(1) << vecs[i].rq;
      wait_write(n, g);
      check({vecs[i].name, "_latency"}, 32'(n), 32'(LAT));
      check({vecs[i].name, "_gnt_cycles"}, 32'(g), 32'(LAT));
      check({vecs[i].name, "_din"}, y_out_din, vecs[i].exp);
      check({vecs[i].name, "_id"}, 32'(y_out_id), 32'(vecs[i].rq));
      check({vecs[i].name, "_done"}, 32'(done), 32'(2'(1) << vecs[i].rq));
      check({vecs[i].name, "_gnt"}, 32'(gnt), 32'(2'(1) << vecs[i].rq));
      req = 2'b00;
      tick();
      check({vecs[i].name, "_idle_gnt"}, 32'(gnt), 32'd0);
      check({vecs[i].name, "_idle_wr_en"}, 32'(y_out_wr_en), 32'd0);
      check({vecs[i].name, "_idle_done"}, 32'(done), 32'd0);
      check({vecs[i].name, "_din_hold"}, y_out_din, vecs[i].exp);
    end
    check("table_writes", 32'(wr_count), 32'd7);
    check("table_done0", 32'(done0_cnt), 32'(exp_d0));
    check("table_done1", 32'(done1_cnt), 32'(exp_d1));

    set_req_cfg(0, ONE, 32'h0, ONE);
    set_req_cfg(1, 32'h1, 32'h0, HALF);

    // Both requesters held: alternating bursts, one IDLE cycle between.
    do_reset();
    req = 2'b11;
    n = 0;
    g = 0;
    k = 0;
    while (k < 4 && n < 300) begin
      tick();
      n++;
      if (gnt != 2'b00) g++;
      if (y_out_wr_en) begin
        ids[k]  = int'(y_out_id);
        dins[k] = y_out_din;
        cyc[k]  = n;
        k++;
      end
    end
    req = 2'b00;
    check("rr_bursts", 32'(k), 32'd4);
    for (int j = 0; j < k; j++) begin
      check("rr_id", 32'(ids[j]), 32'(j % 2));
      check("rr_din", dins[j], (j % 2 == 0) ? R0_EXP : R1_EXP);
      check("rr_write_cycle", 32'(cyc[j]), 32'(LAT + j * (LAT + 1)));
    end
    check("rr_gnt_cycles", 32'(g), 32'(4 * LAT));
    tick();

    // FIFO full for 10 cycles in WRITE.
    do_reset();
    y_out_full = 1'b1;
    req = 2'b01;
    wr0 = wr_count;
    repeat (LAT) tick();
    for (int j = 0; j < 10; j++) begin
      check("full_no_write", 32'(y_out_wr_en), 32'd0);
      check("full_gnt_held", 32'(gnt), 32'd1);
      check("full_din_held", y_out_din, R0_EXP);
      check("full_no_done", 32'(done), 32'd0);
      if (j < 9) tick();
    end
    tick();
    y_out_full = 1'b0;
    #1;
    check("full_release_wr", 32'(y_out_wr_en), 32'd1);
    check("full_release_din", y_out_din, R0_EXP);
    check("full_release_done", 32'(done), 32'd1);
    req = 2'b00;
    tick();
    tick();
    check("full_one_write", 32'(wr_count - wr0), 32'd1);

    // Reset in the middle of a burst.
    do_reset();
    req = 2'b01;
    wait_write(n, g);
    req = 2'b00;
    tick();
    req = 2'b10;
    wait_tap(5'd15, 2'b10);
    wr0 = wr_count;
    d0  = done0_cnt;
    d1  = done1_cnt;
    reset = 1'b1;
    tick();
    check("mrst_gnt", 32'(gnt), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_wr_en", 32'(y_out_wr_en), 32'd0);
    check("mrst_din", y_out_din, 32'd0);
    check("mrst_id", 32'(y_out_id), 32'd0);
    check("mrst_tap_idx", 32'(tap_idx), 32'd0);
    reset = 1'b0;
    req = 2'b11;
    wait_write(n, g);
    check("mrst_new_latency", 32'(n), 32'(LAT));
    check("mrst_new_id", 32'(y_out_id), 32'd0);
    check("mrst_new_din", y_out_din, R0_EXP);
    req = 2'b00;
    tick();
    check("mrst_writes", 32'(wr_count - wr0), 32'd1);
    check("mrst_done1", 32'(done1_cnt - d1), 32'd0);
    check("mrst_done0", 32'(done0_cnt - d0), 32'd1);

    // Requester 1 drops its request mid-burst.
    do_reset();
    req = 2'b01;
    wait_write(n, g);
    req = 2'b00;
    tick();
    req = 2'b10;
    wait_tap(5'd5, 2'b10);
    d1 = done1_cnt;
    req = 2'b00;
    wait_write(n, g);
    check("drop_latency_rest", 32'(n), 32'(LAT - 6));
    check("drop_id", 32'(y_out_id), 32'd1);
    check("drop_din", y_out_din, R1_EXP);
    check("drop_done", 32'(done), 32'd2);
    tick();
    check("drop_done1_count", 32'(done1_cnt - d1), 32'd1);
    req = 2'b11;
    wait_write(n, g);
    check("drop_next_id", 32'(y_out_id), 32'd0);
    req = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_mac_scheduler.md
FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 Parameter: NUM_TAPS, 32, MAC operations per burst (taps per output sample).
REQ-002 Parameter: N_REQ, 2, number of FIR requesters sharing the MAC.
REQ-003 clock  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  N_REQ  per-requester burst request; a requester holds it high until its done pulse.
REQ-006 gnt  out  N_REQ  one-hot grant, high for the whole burst of the owning requester.
REQ-007 tap_idx  out  $clog2(NUM_TAPS)  tap index presented to the granted requester.
REQ-008 tap_dout  in  N_REQ x DATA_SIZE  per-requester sample for the current tap_idx, combinational from the requester.
REQ-009 coef_dout  in  N_REQ x DATA_SIZE  per-requester coefficient for the current tap_idx, combinational.
REQ-010 done  out  N_REQ  one-cycle pulse to the owning requester when its result is written.
REQ-011 y_out_full  in  1  output FIFO full.
REQ-012 y_out_wr_en  out  1  output FIFO write strobe.
REQ-013 y_out_din  out  DATA_SIZE  accumulated, quantized result.
REQ-014 y_out_id  out  $clog2(N_REQ)  index of the requester owning y_out_din.

Function
REQ-015 The FSM SHALL have states IDLE, MAC, DRAIN and WRITE.
REQ-016 IDLE: if any req bit is high, the block SHALL pick a winner round-robin, latch its index, clear the accumulator, set tap_idx=0 and go to MAC. Otherwise it SHALL stay in IDLE with gnt=0.
REQ-017 Round-robin: search starts at the priority pointer. After each WRITE completes, the pointer SHALL become (winner+1) mod N_REQ.
REQ-018 gnt SHALL be high from the first MAC cycle through the WRITE cycle in which y_out_wr_en fires, inclusive, and low at all other times.
REQ-019 MAC: each cycle the block SHALL register tap_dout and coef_dout of the winner into operand registers and increment tap_idx. The accumulator SHALL add the product of the operands registered in the previous cycle (one-stage pipeline).
REQ-020 MAC SHALL last exactly NUM_TAPS cycles (tap_idx 0..NUM_TAPS-1), then go to DRAIN. tap_idx SHALL NOT wrap inside a burst.
REQ-021 DRAIN SHALL perform the final accumulate in one cycle, then go to WRITE.
REQ-022 Product: signed DATA_SIZE x DATA_SIZE multiply, rounded and rescaled by the shared MULTIPLY_ROUNDING function. The accumulator SHALL be signed DATA_SIZE and wrap modulo 2^DATA_SIZE, with no saturation.
REQ-023 WRITE: while y_out_full=1 the block SHALL hold the result and keep gnt. When y_out_full=0 it SHALL assert y_out_wr_en, y_out_din=acc, y_out_id=winner and done[winner] for one cycle, then go to IDLE.
REQ-024 Latency: with req sampled in IDLE at cycle 0 and the FIFO not full, y_out_wr_en SHALL assert at cycle NUM_TAPS+2.
REQ-025 Deassertion of req[winner] during MAC, DRAIN or WRITE SHALL be ignored; the burst completes. req changes on losing requesters SHALL NOT affect the current burst.
REQ-026 Simultaneous requests SHALL be served one burst at a time, with no idle gap other than the single IDLE cycle.
REQ-027 y_out_wr_en and done SHALL be 0 in all states except WRITE. y_out_din and y_out_id SHALL hold their last value outside WRITE.

Reset
REQ-028 On reset, state=IDLE, gnt=0, done=0, y_out_wr_en=0, y_out_din=0, y_out_id=0, tap_idx=0, accumulator=0, operands=0, pointer=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no FIFO write and no done pulse; the first post-reset grant SHALL go to the lowest-index active requester.

Structure
REQ-030 DATA_SIZE, BITS and MULTIPLY_ROUNDING SHALL come from the shared globals package. The FSM state typedef SHALL be defined in that package.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req, pointer; outputs: one-hot winner, valid).

Verification
REQ-032 Single request req[0], taps all 1.0 (quantized), coefs all 1.0 -> y_out_din=32.0 quantized, y_out_id=0, y_out_wr_en at cycle 34, done[0] for one cycle.
REQ-033 req=2'b11 held -> bursts granted 0,1,0,1; each gnt high for 34 cycles; one IDLE cycle between bursts.
REQ-034 y_out_full=1 for 10 cycles at WRITE -> result held, gnt held, exactly one write when full drops, value unchanged.
REQ-035 Reset asserted at MAC tap_idx=15 -> no write, no done pulse; all outputs 0 the next cycle; new burst starts cleanly.
REQ-036 Mixed-sign taps and coefs (tap k = k-16, coef = -0.5) -> matches the golden model's MULTIPLY_ROUNDING sum bit-exactly, including wrap on overflow.
REQ-037 req[1] dropped at tap_idx=5 of its burst -> burst completes, done[1] pulses, pointer advances to 0.
